// File: rtl/fetch_queue.sv
// fetch_queue: fetch address counter, ROM read issue and FWFT instruction FIFO with redirect flush; optional FETCH_PERF_EN adds bubble_cnt
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [8:0]  redirect_pc,
    output logic        imem_rd,
    output logic [8:0]  imem_addr,
    input  logic [8:0]  imem_data,
    output logic        inst_valid,
    output logic [8:0]  inst,
    output logic [8:0]  inst_pc,
    input  logic        inst_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [8:0]    fpc, ipc;
    logic          inflight, kill, push, pop;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [17:0]   mem [DEPTH];
    // Credit counts the in-flight read so a returning word always has a free slot.
    assign imem_rd    = reset && !redirect && (count + {{AW{1'b0}}, inflight} < (AW+1)'(DEPTH));
    assign imem_addr  = fpc;
    assign push       = inflight && !kill;
    assign inst_valid = count != '0;
    assign pop        = inst_valid && inst_ready;
    assign {inst_pc, inst} = inst_valid ? mem[rd_ptr] : 18'd0;
    always_ff @(posedge clk) begin
        if (push && !redirect)
            mem[wr_ptr] <= {ipc, imem_data};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc      <= '0;
            ipc      <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect) begin
            fpc      <= redirect_pc;
            kill     <= inflight;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= imem_rd;
            kill     <= 1'b0;
            if (imem_rd) begin
                fpc <= fpc + 9'd1;
                ipc <= fpc;
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bubble_cnt <= '0;
        else if (redirect)
            bubble_cnt <= '0;
        else if (inst_ready && !inst_valid && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
    end
`endif
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that consumes the program counter stream and delivers 9-bit instructions to the decoder. It owns a fetch address counter, issues reads to the synchronous instruction ROM, and buffers returned words in a small FIFO. It also absorbs branch redirects by flushing and refetching. It sits between the instruction memory and the decode stage.

## Interface
- `DEPTH`, 4 — FIFO entries (power of two, 2..16).
- `clk` in 1 — clock; all state changes on rising edge.
- `reset` in 1 — asynchronous, active-low; low forces all state to reset values.
- `redirect` in 1 — branch taken this cycle; overrides normal fetch.
- `redirect_pc` in 9 — absolute target address, valid when `redirect`=1.
- `imem_rd` out 1 — read strobe to instruction ROM.
- `imem_addr` out 9 — ROM word address.
- `imem_data` in 9 — ROM read data, valid the cycle after `imem_rd`.
- `inst_valid` out 1 — head of FIFO holds an instruction.
- `inst` out 9 — head instruction.
- `inst_pc` out 9 — address the head instruction was fetched from.
- `inst_ready` in 1 — decoder accepts head this cycle.

## Operation
- State: `fpc`[8:0] (next fetch address), `inflight` (1 bit, a read issued last cycle), `kill` (1 bit, drop the in-flight response), FIFO of {pc, inst} with `count` 0..DEPTH.
- Reset values: `fpc`=0, `inflight`=0, `kill`=0, `count`=0, `imem_rd`=0, `imem_addr`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0.
- Issue: `imem_rd`=1 when `count`+`inflight` < DEPTH and `redirect`=0. `imem_addr`=`fpc`. On issue, `fpc`←`fpc`+1 mod 512, so 511 wraps to 0. There is no other wrap handling.
- Return: when `inflight`=1 and `kill`=0, push {issued pc, `imem_data`}. The pc of an in-flight read is held in a register captured at issue.
- Pop: the head is removed when `inst_valid` and `inst_ready` are both 1. The FIFO is first-word fall-through: `inst`, `inst_pc`, and `inst_valid` are driven from the head entry. A push and a pop in the same cycle leave `count` unchanged.
- Redirect, sampled at edge: `count`←0, `fpc`←`redirect_pc`, `kill`←`inflight`, no issue that cycle. Any response arriving next cycle is discarded. A pop in the redirect cycle is considered accepted by the decoder, but the FIFO is cleared regardless.
- A redirect while `kill`=1 or while the FIFO is empty behaves the same way. Back-to-back redirects use the last target.
- The credit rule guarantees the FIFO never overflows. `inst_valid`=0 whenever `count`=0.

## Timing
- After `reset` rises, cycle C0 has `imem_rd`=1 with `imem_addr`=0. `imem_data` is valid in C1 and pushed at the end of C1. In C2, `inst_valid`=1 and `inst_pc`=0. Fetch-to-decode latency is 2 cycles.
- Steady state with `inst_ready` held at 1: one instruction per cycle, no bubbles.
- Redirect asserted in cycle R: `inst_valid`=0 in R+1 and R+2, and `imem_addr`=`redirect_pc` in R+1. The target instruction appears in R+3. During cycle R itself, outputs still reflect the old head.
- With `inst_ready`=0, issue stops once `count`+`inflight`=DEPTH. Issue resumes the cycle after the first pop.
- `reset` low mid-operation clears all state immediately and drops any in-flight read.

## Configuration
- `FETCH_PERF_EN` defined: adds output `bubble_cnt`[15:0], reset to 0. It increments on each cycle with `inst_ready`=1 and `inst_valid`=0, saturates at 16'hFFFF, and clears on `redirect`. It does not count the redirect cycle itself.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset release, `inst_ready`=1, ROM[i]=i: `inst_valid` rises 2 cycles after reset. `inst_pc` then reads 0,1,2,... every cycle, with `inst`=`inst_pc`[8:0].
- `inst_ready`=0 for 10 cycles after reset with DEPTH=4: `count` reaches 4 and `imem_rd` drops after 4 issues. Raising `inst_ready` yields pc 0..3, then 4 with no gap.
- `redirect`=1, `redirect_pc`=9'h1A0 while one read is in flight: the stale word is never output. `inst_valid`=0 for 2 cycles, then `inst_pc`=1A0, 1A1.
- `redirect_pc`=9'h1FE with `inst_ready`=1: the output pc sequence is 1FE, 1FF, 000, 001.
- Redirect and pop in the same cycle, with `count`=3: the next valid `inst_pc` equals the target and no old entries appear. Then pulse `reset` low for 1 cycle mid-stream: all outputs go to 0 and the restart is from pc 0.
- `FETCH_PERF_EN` defined, redirect every 3rd cycle with `inst_ready`=1: `bubble_cnt` counts 2 per redirect and resets to 0 on each redirect.
